// File: rtl/fixed_dim0_accumulator.sv
// fixed_dim0_accumulator: sums TENSOR_SIZE_DIM_0 signed elements per row, PARALLELISM_DIM_0 lanes per beat.
// One result per row; the output register is back-pressured via valid/ready.
module fixed_dim0_accumulator #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
    localparam int BLOCKS = DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0,
    localparam int OUT_W  = DATA_IN_0_PRECISION_0 + $clog2(DATA_IN_0_TENSOR_SIZE_DIM_0)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0],
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    output logic [OUT_W-1:0]                 data_out_0 [1],
    output logic                             data_out_0_valid,
    input  logic                             data_out_0_ready
);
    localparam int CNT_W = BLOCKS > 1 ? $clog2(BLOCKS) : 1;

    if (DATA_IN_0_TENSOR_SIZE_DIM_0 % DATA_IN_0_PARALLELISM_DIM_0 != 0) begin : g_div_chk
        $error("TENSOR_SIZE_DIM_0 must be divisible by PARALLELISM_DIM_0");
    end
    if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_frac_chk
        $error("fractional bits exceed element width");
    end

    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] beat_sum;
    logic             last;
    logic             in_hs;
    logic             out_hs;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < DATA_IN_0_PARALLELISM_DIM_0; i++)
            beat_sum = beat_sum + OUT_W'($signed(data_in_0[i]));
    end

    assign last            = cnt == CNT_W'(BLOCKS - 1);
    // Only the last beat needs the output register, so only it can be stalled.
    assign data_in_0_ready = !(last && data_out_0_valid && !data_out_0_ready);
    assign in_hs           = data_in_0_valid && data_in_0_ready;
    assign out_hs          = data_out_0_valid && data_out_0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            acc              <= '0;
            data_out_0[0]    <= '0;
            data_out_0_valid <= 1'b0;
        end else begin
            if (out_hs)
                data_out_0_valid <= 1'b0;
            if (in_hs && last) begin
                data_out_0[0]    <= acc + beat_sum;
                data_out_0_valid <= 1'b1;
                acc              <= '0;
                cnt              <= '0;
            end else if (in_hs) begin
                acc <= acc + beat_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fixed_dim0_accumulator.sv
// tb_fixed_dim0_accumulator: scoreboard bench for the default instance plus a BLOCKS == 1 instance.
module tb_fixed_dim0_accumulator;
    localparam int W     = 8;
    localparam int OUT_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W-1:0]     a_din [2];
    logic             a_vin = 1'b0;
    logic             a_rdy;
    logic [OUT_W-1:0] a_dout [1];
    logic             a_vout;
    logic             a_oready = 1'b1;
    logic [W-1:0]     b_din [10];
    logic             b_vin = 1'b0;
    logic             b_rdy;
    logic [OUT_W-1:0] b_dout [1];
    logic             b_vout;
    logic             b_oready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q [$];
    int out_cyc [$];
    int row_sum = 0;
    int beat_idx = 0;
    int cyc = 0;
    int ready_drops = 0;
    bit phase_c = 1'b0;
    bit rand_on = 1'b0;

    fixed_dim0_accumulator dut_a (
        .clk(clk), .rst(rst),
        .data_in_0(a_din), .data_in_0_valid(a_vin), .data_in_0_ready(a_rdy),
        .data_out_0(a_dout), .data_out_0_valid(a_vout), .data_out_0_ready(a_oready)
    );

    fixed_dim0_accumulator #(.DATA_IN_0_PARALLELISM_DIM_0(10)) dut_b (
        .clk(clk), .rst(rst),
        .data_in_0(b_din), .data_in_0_valid(b_vin), .data_in_0_ready(b_rdy),
        .data_out_0(b_dout), .data_out_0_valid(b_vout), .data_out_0_ready(b_oready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: outputs transfer at the next rising edge when valid && ready are seen here.
    always @(negedge clk) begin
        cyc++;
        if (phase_c && !a_rdy)
            ready_drops++;
        if (!rst && a_vout && a_oready) begin
            if (phase_c)
                out_cyc.push_back(cyc);
            if (exp_q.size() == 0)
                check("unexpected_output", $signed(a_dout[0]), 32'h7fffffff);
            else
                check("row_sum", $signed(a_dout[0]), exp_q.pop_front());
        end
    end

    always @(posedge clk)
        if (rand_on) begin
            #1;
            if (rand_on)
                a_oready = 1'($urandom_range(0, 1));
        end

    task automatic send_a(input int l0, input int l1);
        bit ok;
        ok = 1'b0;
        a_din[0] = 8'(l0);
        a_din[1] = 8'(l1);
        a_vin = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (a_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("in_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            row_sum += l0 + l1;
            beat_idx++;
            if (beat_idx == 5) begin
                exp_q.push_back(row_sum);
                row_sum = 0;
                beat_idx = 0;
            end
        end
        a_vin = 1'b0;
    endtask

    task automatic send_b(input int base, input int step);
        for (int i = 0; i < 10; i++)
            b_din[i] = 8'(base + i * step);
        b_vin = 1'b1;
        @(negedge clk);
        check("b_ready", int'(b_rdy), 1);
        @(posedge clk);
        #1;
        b_vin = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        a_din[0] = '0;
        a_din[1] = '0;
        for (int i = 0; i < 10; i++)
            b_din[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(a_vout), 0);
        check("rst_data", int'(a_dout[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(a_rdy), 1);
        check("post_rst_valid", int'(a_vout), 0);
        @(posedge clk);
        #1;

        // Back-to-back row summing to 55, result valid exactly one cycle.
        for (int j = 0; j < 5; j++)
            send_a(2 * j + 1, 2 * j + 2);
        @(negedge clk);
        check("latency_valid", int'(a_vout), 1);
        @(negedge clk);
        check("one_cycle_valid", int'(a_vout), 0);
        @(posedge clk);
        #1;

        // Most negative lanes exercise sign extension.
        for (int j = 0; j < 5; j++)
            send_a(-128, -128);
        @(negedge clk);
        check("neg_raw", int'(a_dout[0]), 32'hB00);
        @(posedge clk);
        #1;

        // Back-pressure: row A held, row B stalls on its last beat.
        a_oready = 1'b0;
        for (int j = 0; j < 5; j++)
            send_a(1, 1);
        for (int j = 0; j < 4; j++)
            send_a(2, 3);
        @(negedge clk);
        check("stall_ready", int'(a_rdy), 0);
        check("held_valid", int'(a_vout), 1);
        check("held_data", $signed(a_dout[0]), 10);
        @(posedge clk);
        #1;
        a_oready = 1'b1;
        send_a(2, 3);
        @(negedge clk);
        check("b_next_valid", int'(a_vout), 1);
        check("b_next_data", $signed(a_dout[0]), 25);
        @(negedge clk);
        check("b_drained", int'(a_vout), 0);
        @(posedge clk);
        #1;

        // Continuous rows: one result every 5 cycles, ready never drops.
        out_cyc.delete();
        ready_drops = 0;
        phase_c = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 5; j++)
                send_a($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        repeat (2) @(negedge clk);
        phase_c = 1'b0;
        check("cont_count", out_cyc.size(), 4);
        check("cont_ready_drops", ready_drops, 0);
        for (int k = 1; k < out_cyc.size(); k++)
            check("cont_spacing", out_cyc[k] - out_cyc[k-1], 5);
        @(posedge clk);
        #1;

        // Reset mid-row discards the partial sum.
        for (int j = 0; j < 3; j++)
            send_a(5, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        row_sum = 0;
        beat_idx = 0;
        @(negedge clk);
        check("midrst_ready", int'(a_rdy), 1);
        check("midrst_valid", int'(a_vout), 0);
        @(posedge clk);
        #1;
        for (int j = 0; j < 5; j++)
            send_a(1, 1);
        @(negedge clk);
        check("no_residue", $signed(a_dout[0]), 10);
        @(posedge clk);
        #1;

        // Random gaps with random output back-pressure.
        rand_on = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 5; j++) begin
                send_a($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        rand_on = 1'b0;
        @(posedge clk);
        #2;
        a_oready = 1'b1;
        repeat (5) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        // BLOCKS == 1: every beat is a complete row.
        send_b(-1, 0);
        @(negedge clk);
        check("b1_valid", int'(b_vout), 1);
        check("b1_sum", $signed(b_dout[0]), -10);
        @(posedge clk);
        #1;
        send_b(1, 1);
        @(negedge clk);
        check("b1_sum2", $signed(b_dout[0]), 55);
        @(negedge clk);
        check("b1_drop", int'(b_vout), 0);
        @(posedge clk);
        #1;
        b_oready = 1'b0;
        send_b(3, 0);
        @(negedge clk);
        check("b1_stall_ready", int'(b_rdy), 0);
        check("b1_held", $signed(b_dout[0]), 30);
        @(posedge clk);
        #1;
        b_oready = 1'b1;
        @(negedge clk);
        check("b1_release_ready", int'(b_rdy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
